// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED fade controller.
// Holds the state encoding, mode encodings and default duty width.
package led_fade_pkg;

  localparam int DEFAULT_DUTY_W = 8;

  localparam logic [1:0] MODE_BREATHE   = 2'd0;
  localparam logic [1:0] MODE_UP_ONCE   = 2'd1;
  localparam logic [1:0] MODE_DOWN_ONCE = 2'd2;
  localparam logic [1:0] MODE_SAW       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP,
    ST_HOLD_H,
    ST_DOWN,
    ST_HOLD_L
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_fade_ctrl_tick_gen.sv
// Duty-step prescaler: counts 0..STEP_DIV-1 while run is high and flags
// the terminal count as a step; clr restarts the count from zero.
module fade_tick_gen
  import led_fade_pkg::*;
#(
  parameter int STEP_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  if (STEP_DIV < 2) begin : g_step_div_chk
    $error("fade_tick_gen: STEP_DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  assign tick = run && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_fade_ctrl.sv
// LED fade sequencer: walks a PWM duty value through breathe, one-shot
// ramp and sawtooth patterns, one duty step per prescaler period.
module led_fade_ctrl
  import led_fade_pkg::*;
#(
  parameter int STEP_DIV   = 500000,
  parameter int HOLD_STEPS = 64,
  parameter int DUTY_W     = DEFAULT_DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done,
  output logic              step_tick
);

  localparam int unsigned HW = cnt_width(HOLD_STEPS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  if (HOLD_STEPS < 1) begin : g_hold_chk
    $error("led_fade_ctrl: HOLD_STEPS must be at least 1");
  end

  state_e            state, state_d;
  logic [DUTY_W-1:0] duty_d;
  logic [HW-1:0]     hold_cnt, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic              done_d, tick_d;
  logic              clr, run, step;

  assign busy = (state != ST_IDLE);
  assign run  = busy && enable;

  fade_tick_gen #(
    .STEP_DIV(STEP_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clr  (clr),
    .tick (step)
  );

  always_comb begin
    state_d = state;
    duty_d  = duty_out;
    hold_d  = hold_cnt;
    mode_d  = mode_q;
    done_d  = 1'b0;
    tick_d  = 1'b0;
    clr     = 1'b0;

    if (stop) begin
      // Abort wins over everything, including a same-cycle start and enable=0.
      state_d = ST_IDLE;
      duty_d  = '0;
      hold_d  = '0;
      clr     = 1'b1;
    end else if (state == ST_IDLE) begin
      if (start && enable) begin
        mode_d = mode;
        clr    = 1'b1;
        hold_d = '0;
        if (mode == MODE_DOWN_ONCE) begin
          duty_d  = DUTY_MAX;
          state_d = ST_DOWN;
        end else begin
          duty_d  = '0;
          state_d = ST_UP;
        end
      end
    end else if (step) begin
      tick_d = 1'b1;
      case (state)
        ST_UP: begin
          if (duty_out == DUTY_MAX) begin
            case (mode_q)
              MODE_BREATHE: begin
                state_d = ST_HOLD_H;
                hold_d  = '0;
              end
              MODE_SAW: duty_d = '0;
              default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            duty_d = duty_out + DUTY_W'(1);
          end
        end
        ST_DOWN: begin
          if (duty_out == '0) begin
            if (mode_q == MODE_BREATHE) begin
              state_d = ST_HOLD_L;
              hold_d  = '0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            duty_d = duty_out - DUTY_W'(1);
          end
        end
        ST_HOLD_H: begin
          if (hold_cnt == HOLD_LAST) begin
            state_d = ST_DOWN;
            hold_d  = '0;
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end
        ST_HOLD_L: begin
          if (hold_cnt == HOLD_LAST) begin
            state_d = ST_UP;
            hold_d  = '0;
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      duty_out  <= '0;
      hold_cnt  <= '0;
      mode_q    <= MODE_BREATHE;
      done      <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      state     <= state_d;
      duty_out  <= duty_d;
      hold_cnt  <= hold_d;
      mode_q    <= mode_d;
      done      <= done_d;
      step_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl: expected duty values are queued when a
// sequence is launched and popped on every step_tick the DUT produces.
module tb_led_fade_ctrl;

  localparam int STEP_DIV   = 4;
  localparam int HOLD_STEPS = 2;
  localparam int DUTY_W     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              done;
  logic              step_tick;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int cyc = 0;
  int last_tick = -1;
  int done_cnt = 0;
  int d0;
  bit gap_chk = 1'b1;

  led_fade_ctrl #(
    .STEP_DIV  (STEP_DIV),
    .HOLD_STEPS(HOLD_STEPS),
    .DUTY_W    (DUTY_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .duty_out (duty_out),
    .busy     (busy),
    .done     (done),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the falling edge, score any step output.
  task automatic cycle();
    int e;
    @(negedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    if (step_tick) begin
      if (exp_q.size() == 0) begin
        chk("spurious_tick", int'(step_tick), 0);
      end else begin
        e = exp_q.pop_front();
        chk("step_duty", int'(duty_out), e);
        if (gap_chk && last_tick >= 0) chk("tick_period", cyc - last_tick, STEP_DIV);
      end
      last_tick = cyc;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_range(input int a, input int b);
    if (a <= b) begin
      for (int v = a; v <= b; v++) exp_q.push_back(v);
    end else begin
      for (int v = a; v >= b; v--) exp_q.push_back(v);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic do_start(input logic [1:0] m);
    mode      = m;
    start     = 1'b1;
    last_tick = -1;
    cycle();
    start     = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  initial begin
    // Reset
    enable = 1'b1;
    cycles(3);
    chk("rst_duty", int'(duty_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tick", int'(step_tick), 0);
    rst_n = 1'b1;
    cycles(2);
    chk("idle_busy", int'(busy), 0);

    // Mode 1: ramp up once
    d0 = done_cnt;
    do_start(2'd1);
    chk("up1_busy", int'(busy), 1);
    chk("up1_duty0", int'(duty_out), 0);
    push_range(1, 255);
    exp_q.push_back(255);
    drain("up1", 1100);
    chk("up1_done", done_cnt, d0 + 1);
    chk("up1_busy_end", int'(busy), 0);
    chk("up1_duty_end", int'(duty_out), 255);
    cycles(6);
    chk("up1_duty_hold", int'(duty_out), 255);
    chk("up1_done_once", done_cnt, d0 + 1);

    // Mode 0: breathe full cycle then back into UP
    d0 = done_cnt;
    do_start(2'd0);
    chk("br_duty0", int'(duty_out), 0);
    push_range(1, 255);
    push_range(255, 255); push_range(255, 255); push_range(255, 255);
    push_range(254, 0);
    push_range(0, 0); push_range(0, 0); push_range(0, 0);
    push_range(1, 3);
    drain("br", 2200);
    chk("br_busy", int'(busy), 1);
    chk("br_duty", int'(duty_out), 3);
    chk("br_no_done", done_cnt, d0);

    // Stop overrides a same-cycle start while busy
    stop  = 1'b1;
    start = 1'b1;
    mode  = 2'd2;
    cycle();
    stop  = 1'b0;
    start = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_duty", int'(duty_out), 0);
    cycles(8);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", int'(busy), 0);
    do_stop();
    chk("idle_stop_duty", int'(duty_out), 0);
    chk("idle_stop_busy", int'(busy), 0);
    chk("idle_stop_done", done_cnt, d0);

    // Mode 3: sawtooth wraps, start while busy ignored
    do_start(2'd3);
    push_range(1, 255);
    exp_q.push_back(0);
    push_range(1, 2);
    mode  = 2'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    drain("saw", 1100);
    chk("saw_busy", int'(busy), 1);
    chk("saw_no_done", done_cnt, d0);
    do_stop();
    chk("saw_stop_busy", int'(busy), 0);
    chk("saw_stop_duty", int'(duty_out), 0);

    // Freeze at duty 37 one cycle into a step period
    do_start(2'd1);
    push_range(1, 37);
    drain("frz_pre", 200);
    cycle();
    enable  = 1'b0;
    gap_chk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("frz_duty", int'(duty_out), 37);
      chk("frz_tick", int'(step_tick), 0);
    end
    enable = 1'b1;
    exp_q.push_back(38);
    cycle();
    chk("resume_tick1", int'(step_tick), 0);
    cycle();
    chk("resume_tick2", int'(step_tick), 0);
    cycle();
    chk("resume_tick3", int'(step_tick), 1);
    chk("resume_duty", int'(duty_out), 38);
    gap_chk = 1'b1;
    do_stop();
    chk("frz_no_done", done_cnt, d0);

    // Mode 2 reset mid-ramp, then immediate restart
    do_start(2'd2);
    chk("dn_duty0", int'(duty_out), 255);
    push_range(254, 100);
    drain("dn", 700);
    chk("dn_duty", int'(duty_out), 100);
    rst_n = 1'b0;
    cycle();
    chk("mrst_duty", int'(duty_out), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_tick", int'(step_tick), 0);
    rst_n     = 1'b1;
    mode      = 2'd2;
    start     = 1'b1;
    last_tick = -1;
    cycle();
    start = 1'b0;
    chk("restart_duty", int'(duty_out), 255);
    chk("restart_busy", int'(busy), 1);
    do_stop();
    chk("final_no_done", done_cnt, d0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
